// File: rtl/dmem_arbiter.sv
// Arbitrates cpu/dbg access to a single-port data memory; fixed cpu priority with a dbg starvation guard.
// Latency accept->done: write 2 cycles, read 3; requesters are held off (gnt low) while an access is in flight.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int WDATA_W      = 32,
    parameter int RDATA_W      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WDATA_W-1:0] cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_done,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [ADDR_W-1:0]  dbg_addr,
    input  logic [WDATA_W-1:0] dbg_wdata,
    output logic               dbg_gnt,
    output logic               dbg_done,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               mem_read_flag,
    output logic               mem_write_flag,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDATA_W-1:0] mem_rdata,
    output logic               busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] CAPT  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic       owner;      // 0 = cpu, 1 = dbg
    logic [3:0] starve_cnt;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (state == IDLE) begin
            if (dbg_req && starve_cnt == LIMIT) dbg_gnt = 1'b1;
            else if (cpu_req)                   cpu_gnt = 1'b1;
            else if (dbg_req)                   dbg_gnt = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            starve_cnt     <= 4'd0;
            mem_read_flag  <= 1'b0;
            mem_write_flag <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            rsp_rdata      <= '0;
            cpu_done       <= 1'b0;
            dbg_done       <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && cpu_gnt) begin
                        owner          <= 1'b0;
                        mem_addr       <= cpu_addr;
                        mem_wdata      <= cpu_wdata;
                        mem_write_flag <= cpu_we;
                        mem_read_flag  <= ~cpu_we;
                        state          <= ISSUE;
                        if (dbg_req && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (dbg_req && dbg_gnt) begin
                        owner          <= 1'b1;
                        mem_addr       <= dbg_addr;
                        mem_wdata      <= dbg_wdata;
                        mem_write_flag <= dbg_we;
                        mem_read_flag  <= ~dbg_we;
                        state          <= ISSUE;
                        starve_cnt     <= 4'd0;
                    end
                end
                ISSUE: begin
                    mem_read_flag  <= 1'b0;
                    mem_write_flag <= 1'b0;
                    // Writes complete here; reads need one more cycle for the registered memory output.
                    if (mem_write_flag) begin
                        state    <= IDLE;
                        cpu_done <= ~owner;
                        dbg_done <= owner;
                    end else begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    rsp_rdata <= mem_rdata;
                    cpu_done  <= ~owner;
                    dbg_done  <= owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory, per-requester drivers and a done-driven scoreboard.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [63:0] exp;
    } op_t;

    typedef struct {
        logic        owner;
        logic        we;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
    logic [63:0] rsp_rdata;
    logic        mem_read_flag, mem_write_flag;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        busy;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .rsp_rdata(rsp_rdata), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with one-cycle registered read.
    logic [63:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_write_flag) mem[mem_addr] <= {32'b0, mem_wdata};
        if (mem_read_flag)  mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t sbq[$];
    op_t cpu_ops[$];
    op_t dbg_ops[$];
    logic gnt_log[$];
    logic [63:0] last_rsp = '0;
    int cpu_gnt_cyc = 0;
    int dbg_gnt_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [63:0] exp);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata; o.exp = exp;
        return o;
    endfunction

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cpu_gnt && dbg_gnt) chk("gnt_exclusive", 64'(2'b11), 64'(2'b01));
            if (cpu_done || dbg_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'({cpu_done, dbg_done}), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_owner", 64'({cpu_done, dbg_done}), e.owner ? 64'd1 : 64'd2);
                    chk("done_latency", 64'(cyc), 64'(e.cyc));
                    if (e.we) begin
                        chk("rsp_hold_on_write", rsp_rdata, last_rsp);
                    end else begin
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        last_rsp = e.rdata;
                    end
                end
            end
        end
    end

    task automatic issue_push(input logic owner, input op_t o);
        exp_t e;
        e.owner = owner;
        e.we    = o.we;
        e.rdata = o.exp;
        e.cyc   = cyc + (o.we ? 2 : 3);
        sbq.push_back(e);
        gnt_log.push_back(owner);
    endtask

    task automatic run_cpu();
        op_t o;
        bit  got;
        while (cpu_ops.size() > 0) begin
            o = cpu_ops.pop_front();
            cpu_req = 1'b1; cpu_we = o.we; cpu_addr = o.addr; cpu_wdata = o.wdata;
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (cpu_gnt) got = 1'b1;
            end
            if (!got) begin
                chk("cpu_gnt_timeout", 64'd0, 64'd1);
            end else begin
                cpu_gnt_cyc = cyc;
                issue_push(1'b0, o);
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic run_dbg();
        op_t o;
        bit  got;
        while (dbg_ops.size() > 0) begin
            o = dbg_ops.pop_front();
            dbg_req = 1'b1; dbg_we = o.we; dbg_addr = o.addr; dbg_wdata = o.wdata;
            got = 1'b0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (dbg_gnt) got = 1'b1;
            end
            if (!got) begin
                chk("dbg_gnt_timeout", 64'd0, 64'd1);
            end else begin
                dbg_gnt_cyc = cyc;
                issue_push(1'b1, o);
            end
            @(posedge clk); #1;
        end
        dbg_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < 100 && !done_ok; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) done_ok = 1'b1;
        end
        if (!done_ok) begin
            chk("idle_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic exp_order [8];
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_order [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset and idle checks
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_read_flag", 64'(mem_read_flag), 64'd0);
        chk("rst_write_flag", 64'(mem_write_flag), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rsp", rsp_rdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("idle_gnts", 64'({cpu_gnt, dbg_gnt}), 64'd0);
        chk("rst_dones", 64'({cpu_done, dbg_done}), 64'd0);
        @(posedge clk); #1;

        // Single cpu write then read of address 6
        cpu_ops.push_back(mk(1'b1, 8'd6, 32'h0000_00AB, 64'd0));
        run_cpu();
        chk("wr_issue_flag", 64'({mem_write_flag, mem_read_flag}), 64'd2);
        chk("wr_issue_addr", 64'(mem_addr), 64'd6);
        chk("wr_issue_data", 64'(mem_wdata), 64'h0000_00AB);
        chk("wr_issue_busy", 64'(busy), 64'd1);
        wait_idle();
        cpu_ops.push_back(mk(1'b0, 8'd6, 32'd0, 64'h0000_0000_0000_00AB));
        run_cpu();
        chk("rd_issue_flag", 64'({mem_write_flag, mem_read_flag}), 64'd1);
        chk("rd_issue_addr", 64'(mem_addr), 64'd6);
        wait_idle();

        // Both requesters held: cpu x4, dbg, cpu x2, dbg
        gnt_log.delete();
        cpu_ops.push_back(mk(1'b1, 8'd10, 32'h11, 64'd0));
        cpu_ops.push_back(mk(1'b1, 8'd11, 32'h22, 64'd0));
        cpu_ops.push_back(mk(1'b1, 8'd12, 32'h33, 64'd0));
        cpu_ops.push_back(mk(1'b0, 8'd10, 32'd0, 64'h11));
        cpu_ops.push_back(mk(1'b1, 8'd13, 32'h44, 64'd0));
        cpu_ops.push_back(mk(1'b0, 8'd12, 32'd0, 64'h33));
        dbg_ops.push_back(mk(1'b0, 8'd6, 32'd0, 64'hAB));
        dbg_ops.push_back(mk(1'b0, 8'd10, 32'd0, 64'h11));
        fork
            run_cpu();
            run_dbg();
        join
        wait_idle();
        chk("gnt_log_len", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < gnt_log.size()) chk($sformatf("gnt_order_%0d", i), 64'(gnt_log[i]), 64'(exp_order[i]));

        // Back-to-back: dbg read granted in the cycle cpu write completes
        cpu_ops.push_back(mk(1'b1, 8'd20, 32'h55, 64'd0));
        dbg_ops.push_back(mk(1'b0, 8'd20, 32'd0, 64'h55));
        fork
            run_cpu();
            run_dbg();
        join
        chk("b2b_gnt_cycle", 64'(dbg_gnt_cyc), 64'(cpu_gnt_cyc + 2));
        wait_idle();

        // Reset during CAPT of a dbg read aborts it silently
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd6;
        @(negedge clk);
        chk("abort_dbg_gnt", 64'(dbg_gnt), 64'd1);
        @(posedge clk); #1;
        dbg_req = 1'b0;
        chk("abort_issue_rd", 64'(mem_read_flag), 64'd1);
        @(posedge clk); #1;
        chk("abort_capt_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_flags", 64'({mem_read_flag, mem_write_flag}), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rsp", rsp_rdata, 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        last_rsp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 64'({cpu_done, dbg_done}), 64'd0);
        @(posedge clk); #1;

        // Post-reset traffic, unwritten address, write leaves rsp_rdata alone
        cpu_ops.push_back(mk(1'b0, 8'd6, 32'd0, 64'hAB));
        run_cpu();
        wait_idle();
        dbg_ops.push_back(mk(1'b0, 8'd200, 32'd0, 64'd0));
        run_dbg();
        wait_idle();
        cpu_ops.push_back(mk(1'b1, 8'd200, 32'h77, 64'd0));
        run_cpu();
        wait_idle();
        chk("rsp_after_write", rsp_rdata, 64'd0);
        dbg_ops.push_back(mk(1'b0, 8'd200, 32'd0, 64'h77));
        run_dbg();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
